// File: rtl/ec_cpu_param.sv
// Accumulator CPU with operator Enter strobe, IN/OUT and program-load port.
// Optional macro EC_CPU_HALT_RESUME_EN: an Enter event in HALT resumes fetching at the current PC.
module ec_cpu_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enter,
    input  logic [DATA_W-1:0] Input,
    input  logic              LdWr,
    input  logic [ADDR_W-1:0] LdAddr,
    input  logic [DATA_W-1:0] LdData,
    output logic [DATA_W-1:0] Output,
    output logic              Halt,
    output logic [3:0]        state
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd8,
        S_STORE  = 4'd9,
        S_ADD    = 4'd10,
        S_SUB    = 4'd11,
        S_IN     = 4'd12,
        S_JZ     = 4'd13,
        S_JPOS   = 4'd14,
        S_HALT   = 4'd15
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] a_q;
    logic              enter_q;
    logic              arm_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [2:0]        opcode;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] operand;
    logic              enter_ev;
    logic              unused_ir;

    assign opcode    = ir_q[DATA_W-1 -: 3];
    assign addr      = ir_q[ADDR_W-1:0];
    assign operand   = mem[addr];
    assign unused_ir = ^ir_q;

    // arm_q blocks an Enter held high across reset release from counting as an edge
    assign enter_ev = Enter & ~enter_q & arm_q;

    assign Output = a_q;
    assign Halt   = (state_q == S_HALT);
    assign state  = state_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_START;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            enter_q <= 1'b0;
            arm_q   <= 1'b0;
        end else begin
            enter_q <= Enter;
            arm_q   <= arm_q | ~Enter;
            case (state_q)
                S_START: begin
                    if (enter_ev) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    ir_q    <= mem[pc_q];
                    pc_q    <= pc_q + 1'b1;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    state_q <= state_t'({1'b1, opcode});
                end
                S_LOAD: begin
                    a_q     <= operand;
                    state_q <= S_FETCH;
                end
                S_STORE: begin
                    state_q <= S_FETCH;
                end
                S_ADD: begin
                    a_q     <= a_q + operand;
                    state_q <= S_FETCH;
                end
                S_SUB: begin
                    a_q     <= a_q - operand;
                    state_q <= S_FETCH;
                end
                S_IN: begin
                    if (enter_ev) begin
                        a_q     <= Input;
                        state_q <= S_FETCH;
                    end
                end
                S_JZ: begin
                    if (a_q == '0) pc_q <= addr;
                    state_q <= S_FETCH;
                end
                S_JPOS: begin
                    if (!a_q[DATA_W-1] && (a_q != '0)) pc_q <= addr;
                    state_q <= S_FETCH;
                end
                S_HALT: begin
`ifdef EC_CPU_HALT_RESUME_EN
                    if (enter_ev) state_q <= S_FETCH;
`else
                    state_q <= S_HALT;
`endif
                end
                default: state_q <= S_START;
            endcase
        end
    end

    // Memory is deliberately outside the reset domain so programs and STOREs survive reset
    always_ff @(posedge Clock) begin
        if (state_q == S_STORE) begin
            mem[addr] <= a_q;
        end else if (LdWr && ((state_q == S_START) || (state_q == S_HALT))) begin
            mem[LdAddr] <= LdData;
        end
    end

endmodule

// File: tb/tb_ec_cpu_param.sv
// Scoreboard bench for ec_cpu_param: expected accumulator values queued per program, checked at HALT.
module tb_ec_cpu_param;

    logic       Clock;
    logic       Reset;
    logic       Enter;
    logic [7:0] Input;
    logic       LdWr;
    logic [4:0] LdAddr;
    logic [7:0] LdData;
    logic [7:0] Output;
    logic       Halt;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    ec_cpu_param #(.DATA_W(8), .ADDR_W(5)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Enter (Enter),
        .Input (Input),
        .LdWr  (LdWr),
        .LdAddr(LdAddr),
        .LdData(LdData),
        .Output(Output),
        .Halt  (Halt),
        .state (state)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic do_reset();
        Reset = 1'b0;
        Enter = 1'b0;
        LdWr  = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
    endtask

    task automatic load_word(input logic [4:0] a, input logic [7:0] d);
        LdWr   = 1'b1;
        LdAddr = a;
        LdData = d;
        @(negedge Clock);
        LdWr   = 1'b0;
    endtask

    task automatic pulse_enter();
        Enter = 1'b1;
        @(negedge Clock);
        Enter = 1'b0;
        @(negedge Clock);
    endtask

    task automatic wait_state(input logic [3:0] target, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (state == target) hit = 1'b1;
            else @(negedge Clock);
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout waiting for state %0d, state=%0d", name, target, state);
        end
    endtask

    task automatic run_to_halt(input string name);
        bit done = 1'b0;
        logic [7:0] exp;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge Clock);
            if (Halt === 1'b1) done = 1'b1;
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            exp = exp_q.pop_front();
            if (!done) begin
                failures++;
                $display("FAIL %s: halt timeout state=%0d, expected Output=%02h", name, state, exp);
            end else if (Output !== exp) begin
                failures++;
                $display("FAIL %s: Output=%02h expected=%02h", name, Output, exp);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Enter = 1'b0;
        LdWr  = 1'b0;
        Input = 8'h00;
        LdAddr = '0;
        LdData = '0;
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL reset_state: state=%0d expected=0", state); end
        checks++;
        if (Output !== 8'h00) begin failures++; $display("FAIL reset_output: Output=%02h expected=00", Output); end
        checks++;
        if (Halt !== 1'b0) begin failures++; $display("FAIL reset_halt: Halt=%b expected=0", Halt); end
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        repeat (3) @(negedge Clock);
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL start_hold: state=%0d expected=0", state); end
    endtask

    task automatic test_program();
        load_word(5'd0, 8'h80);
        load_word(5'd1, 8'h5E);
        load_word(5'd2, 8'h3F);
        load_word(5'd3, 8'hE0);
        load_word(5'd30, 8'h05);
        exp_q.push_back(8'h0F);
        pulse_enter();
        wait_state(4'd12, "program_in");
        Input = 8'h0A;
        pulse_enter();
        run_to_halt("program_out");
        checks++;
        if (Halt !== 1'b1) begin failures++; $display("FAIL program_halt: Halt=%b expected=1", Halt); end
        checks++;
        if (state !== 4'd15) begin failures++; $display("FAIL program_state: state=%0d expected=15", state); end
    endtask

    task automatic test_wrap();
        do_reset();
        load_word(5'd0, 8'h1E);
        load_word(5'd1, 8'h5D);
        load_word(5'd2, 8'hE0);
        load_word(5'd30, 8'hFF);
        load_word(5'd29, 8'h02);
        exp_q.push_back(8'h01);
        pulse_enter();
        run_to_halt("add_wrap");
        do_reset();
        load_word(5'd0, 8'h1D);
        load_word(5'd1, 8'h7E);
        exp_q.push_back(8'h03);
        pulse_enter();
        run_to_halt("sub_wrap");
    endtask

    task automatic test_jumps();
        do_reset();
        load_word(5'd20, 8'h00);
        load_word(5'd21, 8'h33);
        load_word(5'd22, 8'h80);
        load_word(5'd23, 8'h01);
        load_word(5'd10, 8'h15);
        load_word(5'd11, 8'hE0);
        load_word(5'd0, 8'h14);
        load_word(5'd1, 8'hAA);
        load_word(5'd2, 8'hE0);
        exp_q.push_back(8'h33);
        pulse_enter();
        run_to_halt("jz_taken");
        do_reset();
        load_word(5'd0, 8'h16);
        load_word(5'd1, 8'hCA);
        exp_q.push_back(8'h80);
        pulse_enter();
        run_to_halt("jpos_negative");
        do_reset();
        load_word(5'd0, 8'h17);
        exp_q.push_back(8'h33);
        pulse_enter();
        run_to_halt("jpos_taken");
    endtask

    task automatic test_in_hold();
        do_reset();
        load_word(5'd0, 8'h80);
        load_word(5'd1, 8'hE0);
        load_word(5'd2, 8'hE0);
        exp_q.push_back(8'h5A);
        Input = 8'h5A;
        Enter = 1'b1;
        @(negedge Clock);
        wait_state(4'd12, "in_hold_enter");
        repeat (4) @(negedge Clock);
        checks++;
        if (state !== 4'd12) begin failures++; $display("FAIL in_held_high: state=%0d expected=12", state); end
        LdWr   = 1'b1;
        LdAddr = 5'd1;
        LdData = 8'h00;
        @(negedge Clock);
        LdWr  = 1'b0;
        Enter = 1'b0;
        @(negedge Clock);
        checks++;
        if (state !== 4'd12) begin failures++; $display("FAIL in_after_fall: state=%0d expected=12", state); end
        pulse_enter();
        run_to_halt("in_ldwr_ignored");
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_word(5'd0, 8'h1D);
        load_word(5'd1, 8'h5E);
        load_word(5'd2, 8'hE0);
        load_word(5'd29, 8'h02);
        load_word(5'd30, 8'h05);
        pulse_enter();
        wait_state(4'd10, "mid_reach_add");
        Reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0) begin failures++; $display("FAIL midreset_state: state=%0d expected=0", state); end
        checks++;
        if (Output !== 8'h00) begin failures++; $display("FAIL midreset_output: Output=%02h expected=00", Output); end
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        load_word(5'd0, 8'h1F);
        load_word(5'd1, 8'hE0);
        exp_q.push_back(8'h0F);
        pulse_enter();
        run_to_halt("m31_retained");
    endtask

    task automatic test_halt();
        do_reset();
        load_word(5'd0, 8'hE0);
        load_word(5'd1, 8'h15);
        load_word(5'd2, 8'hE0);
        load_word(5'd21, 8'h33);
        pulse_enter();
        wait_state(4'd15, "halt_reach");
        checks++;
        if (Output !== 8'h00) begin failures++; $display("FAIL halt_first: Output=%02h expected=00", Output); end
        Enter = 1'b1;
        @(negedge Clock);
        Enter = 1'b0;
`ifdef EC_CPU_HALT_RESUME_EN
        checks++;
        if (state !== 4'd1) begin failures++; $display("FAIL halt_resume: state=%0d expected=1", state); end
        exp_q.push_back(8'h33);
        run_to_halt("halt_resume_pc");
`else
        checks++;
        if (state !== 4'd15) begin failures++; $display("FAIL halt_stay: state=%0d expected=15", state); end
        repeat (6) @(negedge Clock);
        checks++;
        if (state !== 4'd15 || Output !== 8'h00) begin
            failures++;
            $display("FAIL halt_stay_late: state=%0d Output=%02h expected 15/00", state, Output);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_program();
        test_wrap();
        test_jumps();
        test_in_hold();
        test_reset_mid();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ec_cpu_param.md
EC_CPU_PARAM -- requirements
Module: ec_cpu_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning accumulator/memory word width; legal only if DATA_W >= ADDR_W+3.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; memory depth 2^ADDR_W words.
REQ-003 Clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Enter  input  1  operator strobe (level); rising edge used.
REQ-006 Input  input  DATA_W  operand for the IN instruction.
REQ-007 LdWr  input  1  program-load write enable.
REQ-008 LdAddr  input  ADDR_W  program-load address.
REQ-009 LdData  input  DATA_W  program-load data.
REQ-010 Output  output  DATA_W  current accumulator A.
REQ-011 Halt  output  1  high while in HALT state.
REQ-012 state  output  4  current FSM state code.

Function
REQ-013 SHALL hold internal registers PC[ADDR_W], IR[DATA_W], A[DATA_W], Enter_d, and memory M[2^ADDR_W] of DATA_W with combinational read.
REQ-014 SHALL decode IR as opcode = IR[DATA_W-1:DATA_W-3], addr = IR[ADDR_W-1:0]; the remaining bits are ignored.
REQ-015 SHALL define enter_ev = Enter & ~Enter_d, with Enter_d <= Enter every cycle.
REQ-016 SHALL use the following state codes: START=0, FETCH=1, DECODE=2, LOAD=8, STORE=9, ADD=10, SUB=11, IN=12, JZ=13, JPOS=14, HALT=15.
REQ-017 START SHALL hold until enter_ev, then go to FETCH.
REQ-018 FETCH SHALL do IR <= M[PC] and PC <= PC+1 (modulo 2^ADDR_W, wrap 31->0), then go to DECODE.
REQ-019 DECODE SHALL map opcode 000..111 to LOAD, STORE, ADD, SUB, IN, JZ, JPOS, HALT respectively.
REQ-020 LOAD SHALL do A <= M[addr], then go to FETCH.
REQ-021 STORE SHALL do M[addr] <= A, then go to FETCH.
REQ-022 ADD SHALL do A <= A+M[addr], then go to FETCH.
REQ-023 SUB SHALL do A <= A-M[addr], then go to FETCH; both ADD and SUB wrap modulo 2^DATA_W with no carry or overflow kept.
REQ-024 IN SHALL hold until enter_ev, then do A <= Input and go to FETCH; an Enter held high from before entering IN SHALL NOT count as an event.
REQ-025 JZ SHALL do PC <= addr if A == 0, then go to FETCH.
REQ-026 JPOS SHALL do PC <= addr if A[DATA_W-1] == 0 and A != 0, then go to FETCH.
REQ-027 HALT SHALL assert Halt and stay in HALT (subject to REQ-033).
REQ-028 LdWr SHALL write M[LdAddr] <= LdData only in START or HALT; in every other state it SHALL be ignored.
REQ-029 Output SHALL equal A combinationally from the register, with zero added latency.

Reset
REQ-030 Reset low SHALL immediately force PC=0, IR=0, A=0, Enter_d=0, state=START; Output=0 and Halt=0 follow.
REQ-031 Memory contents SHALL be unaffected by reset; a reset in mid-program retains any prior STOREs.
REQ-032 After Reset is released, the first enter_ev SHALL require Enter low for at least one clock after release.

Configuration
REQ-033 With EC_CPU_HALT_RESUME_EN defined, enter_ev in HALT SHALL go to FETCH with PC unchanged; without it, HALT SHALL exit only on reset.

Verification
REQ-034 Load M0=0x80, M1=0x5E, M2=0x3F, M3=0xE0, M30=0x05; pulse Enter; set Input=0x0A and pulse Enter in IN -> Output=0x0F, M31=0x0F, Halt=1, state=15.
REQ-035 Program LOAD 30 (M30=0xFF), ADD 29 (M29=0x02), HALT -> Output=0x01, showing wrap-around.
REQ-036 Program with A=0x00 then JZ 10 -> next FETCH reads M10; with A=0x80, JPOS 10 is not taken; with A=0x01, JPOS 10 is taken.
REQ-037 Hold Enter high across entry into IN -> state stays 12 until Enter falls and rises again; LdWr pulsed during IN leaves memory unchanged.
REQ-038 Assert Reset in ADD state -> state=0, Output=0 asynchronously; previously stored M31 is retained.
REQ-039 Enter pulse in HALT -> FETCH at PC+0 with the macro defined; remains state=15 without it.
